// File: rtl/fios_pkg.sv
// fios_pkg: shared types and defaults for the FIOS result unit.
//   state_t    - result unit FSM states
//   word_t     - one S_DEFAULT-bit operand/result word
//   S_DEFAULT  - default word width, NB_DEFAULT - default words per operand
package fios_pkg;
    localparam int S_DEFAULT = 16;
    localparam int NB_DEFAULT = 8;
    typedef enum logic [1:0] {IDLE, COLLECT, SUB, OUTPUT} state_t;
    typedef logic [S_DEFAULT-1:0] word_t;
endpackage

// File: rtl/fios_result_unit_if.sv
// fios_result_unit_if: bundle of the result unit's PE, modulus-memory and output-stream signals.
//   master - the result unit: takes res_push_i/res_i/n_data_i/out_ready_i, drives the rest
//   slave  - the surrounding environment (PE chain, modulus memory, downstream sink)
interface fios_result_unit_if
    import fios_pkg::*;
#(
    parameter int S  = S_DEFAULT,
    parameter int NB = NB_DEFAULT,
    parameter int AW = $clog2(NB)
);
    logic          res_push_i;
    logic [S:0]    res_i;
    logic          n_rd_en_o;
    logic [AW-1:0] n_rd_addr_o;
    logic [S-1:0]  n_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [S-1:0]  out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          error_o;
    modport master (
        input  res_push_i, res_i, n_data_i, out_ready_i,
        output n_rd_en_o, n_rd_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, error_o
    );
    modport slave (
        output res_push_i, res_i, n_data_i, out_ready_i,
        input  n_rd_en_o, n_rd_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, error_o
    );
endinterface

// File: rtl/fios_word_sub.sv
// fios_word_sub: word-serial subtract cell; d/bout = a - b - borrow, borrow registered between words.
//   clk, rst_n - clock, async active-low reset
//   en         - latch bout as the borrow for the next word
//   clr        - clear the borrow (start of a new multiword subtraction)
//   a, b       - minuend / subtrahend words
//   d, bout    - difference word and borrow out of the current word
module fios_word_sub #(
    parameter int S = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    output logic [S-1:0] d,
    output logic         bout
);
    logic borrow;
    // The sign bit of the (S+1)-bit difference is exactly the borrow out.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{S{1'b0}}, borrow};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            borrow <= 1'b0;
        else if (clr)
            borrow <= 1'b0;
        else if (en)
            borrow <= bout;
    end
endmodule

// File: rtl/fios_result_unit.sv
// fios_result_unit: normalises FIOS result blocks, applies the final conditional subtract of N, streams the result.
//   clock_i, reset_n_i - clock, async active-low reset
//   bus (master)       - res_push_i/res_i in; n_rd_en_o/n_rd_addr_o/n_data_i modulus read;
//                        out_valid_o/out_ready_i/out_data_o/out_last_o stream; busy_o, error_o status
module fios_result_unit
    import fios_pkg::*;
#(
    parameter int S  = S_DEFAULT,
    parameter int NB = NB_DEFAULT,
    parameter int AW = $clog2(NB)
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    fios_result_unit_if.master bus
);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(NB - 2);
    localparam logic [CW-1:0] SUB_END = CW'(NB);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    carry;
    logic [1:0]    rtop;
    logic          sel_r;
    logic [S-1:0]  r_buf [NB];
    logic [S-1:0]  d_buf [NB];
    logic [S+1:0]  sum;
    logic [S-1:0]  diff;
    logic          bout;
    logic          sel_next;
    logic [AW-1:0] widx;
    logic [AW-1:0] cn;
    assign sum = {1'b0, bus.res_i} + {{S{1'b0}}, carry};
    // In SUB, cycle cnt consumes the modulus word requested in cycle cnt-1.
    assign widx = AW'(cnt - CW'(1));
    assign cn = AW'(cnt + CW'(1));
    // R < N exactly when the top carry cannot absorb the final borrow.
    assign sel_next = (rtop == 2'd0) && bout;
    fios_word_sub #(.S(S)) u_sub (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .en    (state == SUB && cnt != '0),
        .clr   (state != SUB),
        .a     (r_buf[widx]),
        .b     (bus.n_data_i),
        .d     (diff),
        .bout  (bout)
    );
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            cnt             <= '0;
            carry           <= '0;
            rtop            <= '0;
            sel_r           <= 1'b0;
            bus.n_rd_en_o   <= 1'b0;
            bus.n_rd_addr_o <= '0;
            bus.out_valid_o <= 1'b0;
            bus.out_data_o  <= '0;
            bus.out_last_o  <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.error_o     <= 1'b0;
        end else begin
            if (bus.res_push_i && (state == SUB || state == OUTPUT))
                bus.error_o <= 1'b1;
            case (state)
                IDLE: if (bus.res_push_i) begin
                    r_buf[0]   <= sum[S-1:0];
                    carry      <= sum[S+1:S];
                    cnt        <= CW'(1);
                    bus.busy_o <= 1'b1;
                    state      <= COLLECT;
                end
                COLLECT: if (bus.res_push_i) begin
                    r_buf[cnt[AW-1:0]] <= sum[S-1:0];
                    if (cnt == LAST) begin
                        rtop            <= sum[S+1:S];
                        carry           <= '0;
                        cnt             <= '0;
                        bus.n_rd_en_o   <= 1'b1;
                        bus.n_rd_addr_o <= '0;
                        state           <= SUB;
                    end else begin
                        carry <= sum[S+1:S];
                        cnt   <= cnt + CW'(1);
                    end
                end
                SUB: begin
                    if (cnt != '0)
                        d_buf[widx] <= diff;
                    if (cnt < LAST)
                        bus.n_rd_addr_o <= cn;
                    else begin
                        bus.n_rd_en_o   <= 1'b0;
                        bus.n_rd_addr_o <= '0;
                    end
                    if (cnt == SUB_END) begin
                        sel_r           <= sel_next;
                        cnt             <= '0;
                        bus.out_valid_o <= 1'b1;
                        bus.out_last_o  <= 1'b0;
                        bus.out_data_o  <= sel_next ? r_buf[0] : d_buf[0];
                        state           <= OUTPUT;
                    end else
                        cnt <= cnt + CW'(1);
                end
                OUTPUT: if (bus.out_ready_i) begin
                    if (cnt == LAST) begin
                        cnt             <= '0;
                        bus.out_valid_o <= 1'b0;
                        bus.out_last_o  <= 1'b0;
                        bus.out_data_o  <= '0;
                        bus.busy_o      <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt            <= cnt + CW'(1);
                        bus.out_last_o <= (cnt == PRE_LAST);
                        bus.out_data_o <= sel_r ? r_buf[cn] : d_buf[cn];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
